hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard and forwarding controller. It consumes the destination and control fields leaving the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers (the PipelineMem, PipelineEx and PipelineWB stages) and drives their enable and flush inputs back. It resolves data-memory waits, taken jumps, and load-use hazards. It also produces registered forwarding selects that travel with each instruction into EX.

Parameters:
REG_W, 4, register index width (16 architectural registers, all forwardable, none hardwired).
CNT_W, 16, width of the performance counters (saturating).
MEM_TIMEOUT, 255, maximum number of MEM_WAIT cycles before mem_err is raised.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  IF/ID holds a real instruction
id_R2, id_R3  in  REG_W  source registers of the instruction in ID
id_useR2, id_useR3  in  1  the instruction reads that source
ex_DestR  in  REG_W  ID/EX destination
ex_Wreg, ex_Rmem  in  1  ID/EX write-register and load flags
ex_jmp_taken  in  1  jump/branch resolved taken in EX (from JmpF plus ALU flags)
mem_DestR  in  REG_W  EX/MEM destination
mem_Wreg, mem_Rmem, mem_Wmem  in  1  EX/MEM control flags
mem_ready  in  1  data memory completes the current access this cycle
pc_en, ifid_en, idex_en, exmem_en  out  1  hold enables (1 = advance)
ifid_flush, idex_flush, memwb_flush  out  1  synchronous bubble insert (clears Wreg/Wmem/Rmem/Wpc)
fwdA, fwdB  out  2  registered forwarding selects for ALU operands R2/R3 (00 = register file, 01 = EX/MEM ALURes, 10 = MEM/WB Res)
mem_err  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt  out  CNT_W  stall-cycle and flush-event counters

Behaviour:
- Reset (asynchronous): state = RUN, fwdA/fwdB = 00, counters = 0, mem_err = 0, wait counter = 0. While rst is high, all enables = 0 and all flushes = 0.
- The enable and flush outputs are Mealy (combinational from state and inputs, same cycle). fwd, counters and mem_err are registered.
- States: RUN, MEM_WAIT, LOAD_STALL, FLUSH. Evaluation priority in RUN: memory wait, then jump, then load-use.
- RUN, no hazard: all enables = 1, all flushes = 0.
- RUN with (mem_Rmem|mem_Wmem) & !mem_ready: freeze pc/ifid/idex/exmem, assert memwb_flush, go to MEM_WAIT.
- MEM_WAIT: same outputs as on entry. Go to RUN on the cycle after mem_ready=1; that ready cycle itself advances normally. If the wait counter reaches MEM_TIMEOUT: set mem_err, force RUN, and let the access retire.
- RUN with ex_jmp_taken (no memory wait): assert ifid_flush and idex_flush, hold nothing, go to FLUSH. flush_cnt +1.
- FLUSH: one cycle with all enables = 1, then RUN. Any ex_jmp_taken seen here is ignored because ID/EX is a bubble.
- Load-use hazard: id_valid & ex_Rmem & ex_Wreg & ((id_useR2 & id_R2==ex_DestR) | (id_useR3 & id_R3==ex_DestR)). Response: pc_en = ifid_en = 0, idex_flush = 1, go to LOAD_STALL, which lasts exactly one cycle and then returns to RUN. A second hazard detected in LOAD_STALL is evaluated normally.
- stall_cnt increments on every cycle with pc_en=0 (outside reset) and saturates at all-ones.
- Forwarding, computed in ID and registered when idex_en=1:
  - For each source: match ex_DestR & ex_Wreg -> 01; else match mem_DestR & mem_Wreg -> 10; else 00. The younger producer wins.
  - On an idex_flush cycle the registered selects become 00. When idex_en=0 they hold.
  - Results older than MEM/WB are covered by the write-through register file.
- Simultaneous jump and load-use: the jump wins, and the stalled instruction is flushed.
- A jump during MEM_WAIT is held frozen and acted on after exit.
- rst mid-stall forces RUN immediately.

Decomposition:
- cpu_pkg holds hz_state_t (RUN, MEM_WAIT, LOAD_STALL, FLUSH) and fwd_sel_t with FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- One sub-module, fwd_select: a combinational priority compare for one operand, instantiated twice.
- The FSM, counters and registers live in hazard_ctrl.

Test Plan:
- Reset mid-LOAD_STALL (rst pulsed at t=1) -> enables 0 during reset; then state RUN, fwdA=fwdB=00, stall_cnt=0.
- ex_DestR=7, ex_Wreg=1, ex_Rmem=1, id_R2=7, id_useR2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Next cycle: fwdA=10 registered, stall_cnt=1.
- ex_DestR=5 with ex_Wreg=1 (ALU op), mem_DestR=5 with mem_Wreg=1, id_R3=5 -> no stall, fwdB=01 (youngest wins).
- mem_Rmem=1, mem_ready low for 3 cycles -> 3 cycles of all enables 0 with memwb_flush=1, advance on the ready cycle, stall_cnt=3, mem_err=0.
- ex_jmp_taken=1 together with a load-use condition -> ifid_flush=idex_flush=1 and pc_en=1; flush_cnt=1 and stall_cnt unchanged.
- mem_ready held low for 256 cycles -> mem_err=1 after 255 wait cycles, state back to RUN, mem_err sticky until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the per-cycle control bundle driven back into the pipeline.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        MEM_WAIT   = 2'b01,
        LOAD_STALL = 2'b10,
        FLUSH      = 2'b11
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE    = 2'b00,
        ACT_MEM_FREEZE = 2'b01,
        ACT_JUMP_FLUSH = 2'b10,
        ACT_LOAD_STALL = 2'b11
    } hz_action_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } hz_ctrl_t;

    // Bit order: pc, ifid, idex, exmem enables, then ifid, idex, memwb flushes.
    localparam hz_ctrl_t CTRL_OFF       = 7'b0000_000;
    localparam hz_ctrl_t CTRL_ADVANCE   = 7'b1111_000;
    localparam hz_ctrl_t CTRL_MEM_WAIT  = 7'b0000_001;
    localparam hz_ctrl_t CTRL_JUMP      = 7'b1111_110;
    localparam hz_ctrl_t CTRL_LOAD_USE  = 7'b0011_010;

    function automatic hz_ctrl_t action_ctrl(input hz_action_t act);
        hz_ctrl_t c;
        c = CTRL_OFF;
        case (act)
            ACT_ADVANCE:    c = CTRL_ADVANCE;
            ACT_MEM_FREEZE: c = CTRL_MEM_WAIT;
            ACT_JUMP_FLUSH: c = CTRL_JUMP;
            ACT_LOAD_STALL: c = CTRL_LOAD_USE;
            default:        c = CTRL_OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage fields in, enables,
// flushes, forwarding selects and status out.
interface hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_R2;
    logic [REG_W-1:0] id_R3;
    logic             id_useR2;
    logic             id_useR3;
    logic [REG_W-1:0] ex_DestR;
    logic             ex_Wreg;
    logic             ex_Rmem;
    logic             ex_jmp_taken;
    logic [REG_W-1:0] mem_DestR;
    logic             mem_Wreg;
    logic             mem_Rmem;
    logic             mem_Wmem;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_R2, id_R3, id_useR2, id_useR3,
               ex_DestR, ex_Wreg, ex_Rmem, ex_jmp_taken,
               mem_DestR, mem_Wreg, mem_Rmem, mem_Wmem, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, memwb_flush,
               fwdA, fwdB, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_R2, id_R3, id_useR2, id_useR3,
               ex_DestR, ex_Wreg, ex_Rmem, ex_jmp_taken,
               mem_DestR, mem_Wreg, mem_Rmem, mem_Wmem, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, memwb_flush,
               fwdA, fwdB, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_select.sv
// Forwarding source for one ID operand: the youngest in-flight producer
// of the same register wins, otherwise the register file is used.
module fwd_select
    import cpu_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic             ex_wreg_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             mem_wreg_i,
    output fwd_sel_t         sel_o
);

    // Priority compare, EX/MEM result ahead of MEM/WB result
    always_comb begin
        if (ex_wreg_i && (src_i == ex_dest_i)) begin
            sel_o = FWD_EXMEM;
        end else if (mem_wreg_i && (src_i == mem_dest_i)) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller: resolves memory waits, taken
// jumps and load-use hazards, and registers operand forwarding selects.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hz_state_t        state_q, state_d;
    hz_action_t       action_s;
    hz_ctrl_t         ctrl_s;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic             mem_pend_s;
    logic             timeout_s;
    logic             jmp_act_s;
    logic             load_use_s;
    fwd_sel_t         fwd_a_s, fwd_b_s;
    fwd_sel_t         fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             mem_err_q;

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src_i      (hz.id_R2),
        .ex_dest_i  (hz.ex_DestR),
        .ex_wreg_i  (hz.ex_Wreg),
        .mem_dest_i (hz.mem_DestR),
        .mem_wreg_i (hz.mem_Wreg),
        .sel_o      (fwd_a_s)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src_i      (hz.id_R3),
        .ex_dest_i  (hz.ex_DestR),
        .ex_wreg_i  (hz.ex_Wreg),
        .mem_dest_i (hz.mem_DestR),
        .mem_wreg_i (hz.mem_Wreg),
        .sel_o      (fwd_b_s)
    );

    // Hazard decode; a timed-out access is let through as if it completed.
    // The EX stage is a bubble in FLUSH, so a jump seen there is ignored.
    always_comb begin
        mem_pend_s = (hz.mem_Rmem | hz.mem_Wmem) & ~hz.mem_ready;
        timeout_s  = mem_pend_s & (state_q == MEM_WAIT) &
                     (wait_q == WAIT_W'(MEM_TIMEOUT));
        jmp_act_s  = hz.ex_jmp_taken & (state_q != FLUSH);
        load_use_s = hz.id_valid & hz.ex_Rmem & hz.ex_Wreg &
                     ((hz.id_useR2 & (hz.id_R2 == hz.ex_DestR)) |
                      (hz.id_useR3 & (hz.id_R3 == hz.ex_DestR)));
        if (mem_pend_s && !timeout_s) begin
            action_s = ACT_MEM_FREEZE;
        end else if (jmp_act_s) begin
            action_s = ACT_JUMP_FLUSH;
        end else if (load_use_s) begin
            action_s = ACT_LOAD_STALL;
        end else begin
            action_s = ACT_ADVANCE;
        end
    end

    // FSM state and memory-wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state follows the action chosen this cycle
    always_comb begin
        state_d = RUN;
        wait_d  = '0;
        case (action_s)
            ACT_MEM_FREEZE: begin
                state_d = MEM_WAIT;
                wait_d  = wait_q + WAIT_W'(1);
            end
            ACT_JUMP_FLUSH: state_d = FLUSH;
            ACT_LOAD_STALL: state_d = LOAD_STALL;
            ACT_ADVANCE:    state_d = RUN;
            default:        state_d = RUN;
        endcase
    end

    // Mealy enables/flushes, all held inactive while in reset
    always_comb begin
        if (rst) begin
            ctrl_s = CTRL_OFF;
        end else begin
            ctrl_s = action_ctrl(action_s);
        end
    end

    // Forwarding selects travel with the instruction into EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (ctrl_s.idex_flush) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (ctrl_s.idex_en) begin
            fwd_a_q <= fwd_a_s;
            fwd_b_q <= fwd_b_s;
        end
    end

    // Saturating performance counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            if (!ctrl_s.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((action_s == ACT_JUMP_FLUSH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            mem_err_q <= mem_err_q | timeout_s;
        end
    end

    assign hz.pc_en       = ctrl_s.pc_en;
    assign hz.ifid_en     = ctrl_s.ifid_en;
    assign hz.idex_en     = ctrl_s.idex_en;
    assign hz.exmem_en    = ctrl_s.exmem_en;
    assign hz.ifid_flush  = ctrl_s.ifid_flush;
    assign hz.idex_flush  = ctrl_s.idex_flush;
    assign hz.memwb_flush = ctrl_s.memwb_flush;
    assign hz.fwdA        = fwd_a_q;
    assign hz.fwdB        = fwd_b_q;
    assign hz.mem_err     = mem_err_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

endmodule
